// File: rtl/color_codes_pkg.sv
// color_codes_pkg: colour-code digit constants, FSM states and error causes
// shared by the colour-code encoder and decoder.
package color_codes_pkg;

    localparam logic [11:0] COL_0 = 12'h000;
    localparam logic [11:0] COL_1 = 12'hF00;
    localparam logic [11:0] COL_2 = 12'hF80;
    localparam logic [11:0] COL_3 = 12'hFF0;
    localparam logic [11:0] COL_4 = 12'h0F0;
    localparam logic [11:0] COL_5 = 12'h0FF;
    localparam logic [11:0] COL_6 = 12'h08F;
    localparam logic [11:0] COL_7 = 12'h00F;
    localparam logic [11:0] COL_8 = 12'hF0F;
    localparam logic [11:0] COL_9 = 12'hFFF;

    localparam logic [11:0] COLORS [10] = '{COL_0, COL_1, COL_2, COL_3, COL_4,
                                            COL_5, COL_6, COL_7, COL_8, COL_9};

    typedef enum logic [1:0] {
        S_TENS = 2'd0,
        S_ONES = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_BAD  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_TMO  = 2'd3;

endpackage

// File: rtl/color_digit_decode.sv
// color_digit_decode: maps one 12-bit colour code to its decimal digit;
// unknown codes give digit 0 with valid low.
module color_digit_decode
    import color_codes_pkg::*;
(
    input  logic [11:0] code,
    output logic [3:0]  digit,
    output logic        valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (code == COLORS[i]) begin
                digit = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/color_code_decoder.sv
// color_code_decoder: reassembles a 6-bit number from a tens/ones pair of
// colour digits and reports it with an error cause over valid/ready.
module color_code_decoder
    import color_codes_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_num,
    output logic        out_err,
    output logic [1:0]  out_cause
);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      tens_q, tens_d;
    logic            bad_q, bad_d;
    logic [5:0]      num_q, num_d;
    logic            err_q, err_d;
    logic [1:0]      cause_q, cause_d;
    logic [3:0]      dig;
    logic            dig_ok;
    logic            xfer;
    logic [6:0]      num7;
    logic            expired;

    color_digit_decode u_dec (
        .code  (in_code),
        .digit (dig),
        .valid (dig_ok)
    );

    assign in_ready  = state_q != S_OUT;
    assign out_valid = state_q == S_OUT;
    assign out_num   = num_q;
    assign out_err   = err_q;
    assign out_cause = cause_q;
    assign xfer      = in_valid & in_ready;
    assign num7      = 7'(tens_q) * 7'd10 + 7'(dig);
    assign expired   = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tens_d  = tens_q;
        bad_d   = bad_q;
        num_d   = num_q;
        err_d   = err_q;
        cause_d = cause_q;
        case (state_q)
            S_TENS: if (xfer) begin
                tens_d  = dig;
                bad_d   = !dig_ok;
                timer_d = '0;
                state_d = S_ONES;
            end
            S_ONES: begin
                // A digit landing on the expiry cycle takes precedence over the timeout.
                if (xfer) begin
                    cause_d = (bad_q || !dig_ok) ? CAUSE_BAD : (num7 > 7'd63) ? CAUSE_OVF : CAUSE_NONE;
                    err_d   = cause_d != CAUSE_NONE;
                    num_d   = err_d ? 6'd0 : num7[5:0];
                    state_d = S_OUT;
                end else if (expired) begin
                    cause_d = CAUSE_TMO;
                    err_d   = 1'b1;
                    num_d   = 6'd0;
                    state_d = S_OUT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_OUT: if (out_ready) state_d = S_TENS;
            default: state_d = S_TENS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_TENS;
            timer_q <= '0;
            tens_q  <= 4'd0;
            bad_q   <= 1'b0;
            num_q   <= 6'd0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tens_q  <= tens_d;
            bad_q   <= bad_d;
            num_q   <= num_d;
            err_q   <= err_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_color_code_decoder.sv
// tb_color_code_decoder: directed stimulus with a scoreboard queue; a monitor
// pops expected {num,err,cause} on every output handshake.
module tb_color_code_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_code = 12'h000;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_num;
    logic        out_err;
    logic [1:0]  out_cause;

    int checks = 0;
    int errors = 0;
    bit stall = 1'b0;
    bit pend = 1'b0;
    logic [8:0] exp_q [$];

    logic [11:0] tbl [10] = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                              12'h0FF, 12'h08F, 12'h00F, 12'hF0F, 12'hFFF};

    color_code_decoder #(.TIMEOUT(16), .TW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_err   (out_err),
        .out_cause (out_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare on each output handshake and check out_valid holds under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) chk("hold", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'({out_num, out_err, out_cause}), 32'h1ff);
                else chk("out", 32'({out_num, out_err, out_cause}), 32'(exp_q.pop_front()));
            end
            pend = out_valid && !out_ready;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic push(input int num, input bit err, input int cause);
        exp_q.push_back({6'(num), err, 2'(cause)});
    endtask

    task automatic send(input logic [11:0] c);
        int n;
        in_valid = 1'b1;
        in_code  = c;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 1000) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_code = 12'hxxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'({out_num, out_err, out_cause}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // 25 with latency and single-cycle out_valid.
        push(25, 0, 0);
        send(12'hF80);
        send(12'h0FF);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("one_cycle", 32'(out_valid), 32'd0);
        drain();

        for (int n = 0; n < 64; n++) begin
            push(n, 0, 0);
            send(tbl[n / 10]);
            send(tbl[n % 10]);
        end
        drain();

        stall = 1'b1;
        for (int n = 0; n < 64; n++) begin
            push(n, 0, 0);
            idle($urandom_range(0, 3));
            send(tbl[n / 10]);
            idle($urandom_range(0, 3));
            send(tbl[n % 10]);
        end
        drain();
        stall = 1'b0;
        idle(2);

        push(0, 1, 2);
        send(12'h08F); send(12'hFFF);
        push(0, 1, 1);
        send(12'h123); send(12'h000);
        push(0, 1, 1);
        send(12'hF0F); send(12'h1A1);
        drain();

        // Timeout after 16 idle cycles in S_ONES.
        push(0, 1, 3);
        send(12'hFF0);
        repeat (16) @(negedge clk);
        chk("no_early_tmo", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("tmo_valid", 32'(out_valid), 32'd1);
        drain();
        push(1, 0, 0);
        send(12'h000); send(12'hF00);
        drain();

        // Ones digit on the expiry cycle decodes normally.
        push(35, 0, 0);
        send(12'hFF0);
        idle(15);
        send(12'h0FF);
        drain();

        // Async reset mid-number discards the stored tens digit.
        send(12'hF00);
        idle(2);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        push(40, 0, 0);
        send(12'h0F0); send(12'h000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_code_decoder.md
Name: color_code_decoder

Overview:
- Receive-side counterpart of the colour-code encoder. The encoder maps a 6-bit number to two 12-bit colour digits.
- This block accepts a stream of 12-bit colour digits over a valid/ready handshake, tens digit first, then ones digit.
- It decodes each digit, reassembles the 6-bit number and presents it on a valid/ready output with an error cause.
- It sits between a colour-sensing/capture front end and numeric consumers.

Parameters:
- TIMEOUT, 16, max cycles waiting in S_ONES for the ones digit; 0 disables the timeout.
- TW, 5, width of the timeout counter; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_code holds a digit
- in_ready  out  1  block accepts a digit this cycle
- in_code  in  12  colour digit, RGB 4:4:4
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_num  out  6  decoded number; 0 when out_err=1
- out_err  out  1  result is erroneous
- out_cause  out  2  0 none, 1 bad colour code, 2 overflow (>63), 3 timeout

Behaviour:
- Digit table, code to digit: 000=0, F00=1, F80=2, FF0=3, 0F0=4, 0FF=5, 08F=6, 00F=7, F0F=8, FFF=9.
- Any other code is invalid.
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=S_TENS, in_ready=1, out_valid=0, out_num=0, out_err=0, out_cause=0, timer=0, stored tens=0, bad flag=0.
- Transfer occurs when in_valid & in_ready. Output handshake completes when out_valid & out_ready.
- S_TENS:
  - in_ready=1, out_valid=0.
  - On transfer: store decoded tens digit and its invalid flag, clear timer, go to S_ONES.
- S_ONES:
  - in_ready=1.
  - On transfer, compute num7 = tens*10 + ones in 7 bits, then load the result registers:
    - If either digit is invalid: cause=1, err=1, num=0.
    - Else if num7 > 63: cause=2, err=1, num=0.
    - Else: cause=0, err=0, num=num7[5:0].
    - Then go to S_OUT.
  - Without a transfer: timer increments. When TIMEOUT≠0 and timer reaches TIMEOUT-1 without a transfer, load cause=3, err=1, num=0 and go to S_OUT.
  - A transfer in the same cycle the timer expires wins, so the digit is decoded normally.
- S_OUT:
  - out_valid=1, in_ready=0, result registers stable.
  - On out_ready: go to S_TENS, drop out_valid the next cycle. out_num/out_err/out_cause hold their last value until the next load.
- Latency: out_valid rises on the cycle after the ones-digit transfer.
- Peak throughput: one number per 3 cycles with out_ready held high.
- Backpressure: out_ready low holds S_OUT indefinitely; no input accepted, no data lost.
- Reset mid-operation, any state: immediately returns to the reset values; a partially received number is discarded.
- in_code is ignored when in_valid=0. X on in_code without in_valid must not corrupt state.
- Error priority: cause 1 > cause 2. Timeout only applies in S_ONES.

Decomposition:
- Package color_codes_pkg:
  - 12-bit colour constants for digits 0..9.
  - localparam state encoding S_TENS/S_ONES/S_OUT.
  - Cause constants CAUSE_NONE/BAD/OVF/TMO.
  - The encoder shares the colour constants.
- Sub-module color_digit_decode: combinational, in 12-bit code, out 4-bit digit + valid bit. Instantiated once on in_code.
- The FSM, timer and arithmetic live in the top.

Test Plan:
- Reset, then send F80, 0FF with out_ready=1 → out_num=25, err=0, cause=0; out_valid high exactly 1 cycle, one cycle after the second transfer.
- Sweep 0..63: send encoder output pairs for every n → out_num=n, cause=0 for all; also sweep with random in_valid gaps and random out_ready stalls → no loss or duplication, out_valid held during stalls.
- Send 08F, FFF (=69) → out_err=1, cause=2, out_num=0; send 123, 000 → cause=1, out_num=0; send F0F, 1A1 (overflow digit plus bad code) → cause=1.
- Send FF0, then idle 16 cycles with TIMEOUT=16 → out_valid with cause=3, num=0; a next pair 000, F00 decodes to 1. Ones digit arriving on the expiry cycle → decoded normally.
- Assert rst_n low asynchronously while in S_ONES after tens=F00 → in_ready=1, out_valid=0 immediately. After release, send 0F0, 000 → out_num=40, no stale tens digit.
